// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller with HI/LO registers.
// Multiplies retire after MUL_LAT cycles. Divides use a 4-bit-per-cycle
// restoring divider and always take 10 cycles. mtlo/mthi write in one edge.
// Optional feature: define MDU_FAST_MULT_EN to shorten multiply latency to 1.
module mdu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        rd_sel,
  input  logic        d_mdu_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

`ifdef MDU_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 5;
`endif

  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_CNT_INIT = 4'd9;
  // Divider iterations run while cnt >= this value: 8 edges x 4 bits = 32 bits
  localparam logic [3:0] DIV_STEP_MIN = 4'd2;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_signed;
  logic [32:0] div_rem;
  logic [31:0] div_quo;

  logic        is_mul_op;
  logic        is_div_op;
  logic        is_signed_op;
  logic [31:0] rs_mag;
  logic [31:0] mag_b;
  logic        divisor_zero;
  logic        neg_quo;
  logic        neg_rem;
  logic [31:0] quo_final;
  logic [31:0] rem_final;
  logic signed [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] product;
  logic [32:0] step_rem;
  logic [31:0] step_quo;

  // Decode the E-stage opcode and prepare the dividend magnitude for loading
  always_comb begin
    is_mul_op    = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
    is_div_op    = (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
    is_signed_op = (mdu_op == OP_MULT) || (mdu_op == OP_DIV);
    rs_mag       = (is_signed_op && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
  end

  // Product of the latched operands, signed or unsigned as latched
  always_comb begin
    prod_s  = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
    prod_u  = {32'd0, op_a} * {32'd0, op_b};
    product = op_signed ? $unsigned(prod_s) : prod_u;
  end

  // Divisor magnitude and the sign corrections applied when the divide retires
  always_comb begin
    mag_b        = (op_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;
    divisor_zero = (op_b == 32'd0);
    neg_quo      = op_signed && (op_a[31] ^ op_b[31]);
    neg_rem      = op_signed && op_a[31];
    quo_final    = neg_quo ? (~div_quo + 32'd1) : div_quo;
    rem_final    = neg_rem ? (~div_rem[31:0] + 32'd1) : div_rem[31:0];
  end

  // Four restoring-division iterations per clock on the magnitudes
  always_comb begin
    step_rem = div_rem;
    step_quo = div_quo;
    for (int i = 0; i < 4; i++) begin
      step_rem = {step_rem[31:0], step_quo[31]};
      step_quo = {step_quo[30:0], 1'b0};
      if (step_rem >= {1'b0, mag_b}) begin
        step_rem    = step_rem - {1'b0, mag_b};
        step_quo[0] = 1'b1;
      end
    end
  end

  // Control FSM: operand latch, latency counter, divider datapath and HI/LO commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      op_a      <= 32'd0;
      op_b      <= 32'd0;
      op_signed <= 1'b0;
      div_rem   <= 33'd0;
      div_quo   <= 32'd0;
      hi        <= 32'd0;
      lo        <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul_op) begin
              op_a      <= rs_val;
              op_b      <= rt_val;
              op_signed <= is_signed_op;
              cnt       <= MUL_CNT_INIT;
              state     <= MUL;
            end else if (is_div_op) begin
              op_a      <= rs_val;
              op_b      <= rt_val;
              op_signed <= is_signed_op;
              div_rem   <= 33'd0;
              div_quo   <= rs_mag;
              cnt       <= DIV_CNT_INIT;
              state     <= DIV;
            end else if (mdu_op == OP_MTLO) begin
              lo <= rs_val;
            end else if (mdu_op == OP_MTHI) begin
              hi <= rs_val;
            end
          end
        end
        MUL: begin
          if (cnt == 4'd0) begin
            hi    <= product[63:32];
            lo    <= product[31:0];
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DIV: begin
          if (cnt == 4'd0) begin
            if (!divisor_zero) begin
              hi <= rem_final;
              lo <= quo_final;
            end
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt >= DIV_STEP_MIN) begin
              div_rem <= step_rem;
              div_quo <= step_quo;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Status, hazard stall and committed-register read port
  always_comb begin
    busy    = (state != IDLE);
    stall   = d_mdu_use && (busy || (start && (is_mul_op || is_div_op)));
    rd_data = rd_sel ? hi : lo;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed + short random scoreboard bench for mdu_ctrl.
// Honours MDU_FAST_MULT_EN for the expected multiply latency.
module tb_mdu_ctrl;

`ifdef MDU_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 5;
`endif
  localparam int DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        rd_sel;
  logic        d_mdu_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  int check_count = 0;
  int pass_count  = 0;
  int fail_count  = 0;

  logic [63:0] sb_q[$];
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;
  logic [31:0] prev_hi  = 32'd0;
  logic [31:0] prev_lo  = 32'd0;

  mdu_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mdu_op    (mdu_op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .rd_sel    (rd_sel),
    .d_mdu_use (d_mdu_use),
    .busy      (busy),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo),
    .rd_data   (rd_data)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  // Hard stop in case anything hangs
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 300000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model of {hi,lo} after one operation
  function automatic logic [63:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] cur_hi,
                                               input logic [31:0] cur_lo);
    longint          sa, sb, q, rm;
    longint unsigned ua, ub, uq, urm;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = {cur_hi, cur_lo};
    case (op)
      3'd1: r = sa * sb;
      3'd2: r = ua * ub;
      3'd3: if (b != 32'd0) begin
              q  = sa / sb;
              rm = sa % sb;
              r  = {rm[31:0], q[31:0]};
            end
      3'd4: if (b != 32'd0) begin
              uq  = ua / ub;
              urm = ua % ub;
              r   = {urm[31:0], uq[31:0]};
            end
      3'd5: r = {cur_hi, a};
      3'd6: r = {a, cur_lo};
      default: r = {cur_hi, cur_lo};
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one start at a negedge, record the expected result, release start a cycle later
  task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b);
    logic [63:0] exp_val;
    logic        exp_stall;
    prev_hi = model_hi;
    prev_lo = model_lo;
    exp_val = model_result(op, a, b, model_hi, model_lo);
    sb_q.push_back(exp_val);
    model_hi = exp_val[63:32];
    model_lo = exp_val[31:0];
    start  = 1'b1;
    mdu_op = op;
    rs_val = a;
    rt_val = b;
    #1;
    exp_stall = d_mdu_use && (op >= 3'd1) && (op <= 3'd4);
    checkOutput({tag, " stall_at_start"}, stall, exp_stall);
    @(negedge clk);
    start  = 1'b0;
    mdu_op = 3'd0;
  endtask

  // Pop the scoreboard and compare against committed HI/LO
  task automatic pop_compare(input string tag);
    logic [63:0] exp_val;
    checkOutput({tag, " sb_depth"}, sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      exp_val = sb_q.pop_front();
      checkOutput({tag, " hi"}, hi, exp_val[63:32]);
      checkOutput({tag, " lo"}, lo, exp_val[31:0]);
    end
  endtask

  // Count busy cycles (bounded), checking hold, stall and optionally injecting an ignored start
  task automatic wait_done(input string tag, input int exp_lat, input bit check_stall, input bit inject);
    int cycles = 0;
    while (busy === 1'b1 && cycles < 60) begin
      checkOutput({tag, " hold_hi"}, hi, prev_hi);
      checkOutput({tag, " hold_lo"}, lo, prev_lo);
      if (check_stall) checkOutput({tag, " stall_busy"}, stall, 1);
      if (inject && cycles == 1) begin
        start  = 1'b1;
        mdu_op = 3'd1;
        rs_val = 32'd5;
        rt_val = 32'd7;
      end
      cycles++;
      @(negedge clk);
      start  = 1'b0;
      mdu_op = 3'd0;
    end
    checkOutput({tag, " latency"}, cycles, exp_lat);
    if (check_stall) checkOutput({tag, " stall_after"}, stall, 0);
    pop_compare(tag);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    reset     = 1'b0;
    start     = 1'b0;
    mdu_op    = 3'd0;
    rs_val    = 32'd0;
    rt_val    = 32'd0;
    rd_sel    = 1'b0;
    d_mdu_use = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset hi", hi, 0);
    checkOutput("reset lo", lo, 0);
    checkOutput("reset stall", stall, 0);
    checkOutput("reset rd_data", rd_data, 0);

    // Release and start on the very first edge with reset high
    reset = 1'b1;
    applyStimulus("mult_3_m2", 3'd1, 32'd3, 32'hFFFF_FFFE);
    wait_done("mult_3_m2", MUL_LAT, 1'b0, 1'b0);
    checkOutput("mult_3_m2 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

    applyStimulus("div_7_m2", 3'd3, 32'd7, 32'hFFFF_FFFE);
    wait_done("div_7_m2", DIV_LAT, 1'b0, 1'b0);
    checkOutput("div_7_m2 const", {hi, lo}, {32'd1, 32'hFFFF_FFFD});

    applyStimulus("divu_by_zero", 3'd4, 32'h8000_0000, 32'd0);
    wait_done("divu_by_zero", DIV_LAT, 1'b0, 1'b0);

    // mthi/mtlo with a D-stage MDU user: single-edge write, no stall
    d_mdu_use = 1'b1;
    applyStimulus("mthi", 3'd6, 32'h0000_1234, 32'd0);
    checkOutput("mthi busy", busy, 0);
    pop_compare("mthi");
    rd_sel = 1'b1;
    #1 checkOutput("mthi rd_data", rd_data, 32'h0000_1234);
    applyStimulus("mtlo", 3'd5, 32'hCAFE_F00D, 32'd0);
    pop_compare("mtlo");
    rd_sel = 1'b0;
    #1 checkOutput("mtlo rd_data", rd_data, 32'hCAFE_F00D);

    // No-op opcodes change nothing
    applyStimulus("nop0", 3'd0, 32'hDEAD_BEEF, 32'd1);
    checkOutput("nop0 busy", busy, 0);
    pop_compare("nop0");
    applyStimulus("nop7", 3'd7, 32'hDEAD_BEEF, 32'd1);
    pop_compare("nop7");

    // multu with stall tracking and an ignored second start mid-operation
    applyStimulus("multu_stall", 3'd2, 32'h0001_0000, 32'h0001_0000);
    wait_done("multu_stall", MUL_LAT, 1'b1, 1'b1);
    d_mdu_use = 1'b0;

    // Signed overflow divide and negative dividend
    applyStimulus("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", DIV_LAT, 1'b0, 1'b0);
    checkOutput("div_ovf const", {hi, lo}, {32'd0, 32'h8000_0000});
    applyStimulus("div_m7_2", 3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_m7_2", DIV_LAT, 1'b0, 1'b0);
    applyStimulus("divu_100_7", 3'd4, 32'd100, 32'd7);
    wait_done("divu_100_7", DIV_LAT, 1'b0, 1'b0);

    // All-ones unsigned multiply (single cycle when the fast multiplier is enabled)
    applyStimulus("multu_ones", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_ones", MUL_LAT, 1'b0, 1'b0);
    checkOutput("multu_ones const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    // Short random sweep across the four arithmetic ops
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(1, 4));
      ra  = $urandom;
      rb  = (i == 5) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      applyStimulus("random", rop, ra, rb);
      wait_done("random", (rop <= 3'd2) ? MUL_LAT : DIV_LAT, 1'b0, 1'b0);
    end

    // Asynchronous reset in busy cycle 3 of a divide
    applyStimulus("div_abort", 3'd3, 32'd1000, 32'd7);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("abort busy", busy, 0);
    checkOutput("abort hi", hi, 0);
    checkOutput("abort lo", lo, 0);
    sb_q.delete();
    model_hi = 32'd0;
    model_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    checkOutput("post_abort busy", busy, 0);
    checkOutput("post_abort hi", hi, 0);
    checkOutput("post_abort lo", lo, 0);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
